// File: rtl/multi_debouncer.sv
// N-channel button conditioner: 2-flop sync, symmetric debounce, press/release strobes.
// Optional auto-repeat strobe built when DEBOUNCE_REPEAT_EN is defined.
module multi_debouncer_lane #(
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam int CNT_W = $clog2(STABLE_CYCLES);

    logic [1:0]       sync;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign s      = sync[1];
    assign accept = (s != level) && (cnt == CNT_W'(STABLE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[0], btn_in};
            press <= accept && s;
            rel   <= accept && !s;
            // any sample matching the current level restarts the window
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = $clog2(RMAX + 1);

    logic [RCNT_W-1:0] rcnt;
    logic              first;
    logic [RCNT_W-1:0] target;

    assign target = first ? RCNT_W'(REPEAT_DELAY - 1) : RCNT_W'(REPEAT_PERIOD - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt  <= '0;
            first <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            rpt <= 1'b0;
            // acceptance in either direction restarts; release edge never repeats
            if (accept) begin
                rcnt  <= '0;
                first <= 1'b1;
            end else if (level) begin
                if (rcnt == target) begin
                    rpt   <= 1'b1;
                    rcnt  <= '0;
                    first <= 1'b0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end
    end
`else
    assign rpt = 1'b0;
`endif
endmodule

module multi_debouncer #(
    parameter int CHANNELS      = 5,
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat
);
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        multi_debouncer_lane #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_in(btn_in[g]),
            .level (btn_level[g]),
            .press (btn_press[g]),
            .rel   (btn_release[g]),
            .rpt   (btn_repeat[g])
        );
    end
endmodule

// File: tb/tb_multi_debouncer.sv
// Randomized bench for multi_debouncer against an edge-indexed sample-history model.
module tb_multi_debouncer;
    localparam int CH = 2, S = 4, D = 10, T = 3;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] btn_in = '0;
    logic [CH-1:0] btn_level, btn_press, btn_release, btn_repeat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_debouncer #(
        .CHANNELS(CH), .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_PERIOD(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: history of raw samples per post-reset edge; level flips once the
    // last S synchronised samples (2 edges old) all disagree with it.
    logic [CH-1:0] hist[$];
    int            n;
    logic [CH-1:0] m_lvl, m_press, m_rel, m_rep;
    int            last_chg[CH];
    int            press_e[CH];
    int            left[CH];

    function automatic logic samp(input int c, input int e);
        return (e >= 1) ? hist[e-1][c] : 1'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        n = 0;
        m_lvl = '0; m_press = '0; m_rel = '0; m_rep = '0;
        for (int c = 0; c < CH; c++) begin
            last_chg[c] = 0;
            press_e[c]  = -100000;
        end
    endtask

    task automatic model_edge();
        bit flip;
        n++;
        hist.push_back(btn_in);
        m_press = '0; m_rel = '0; m_rep = '0;
        for (int c = 0; c < CH; c++) begin
            flip = (n - last_chg[c] >= S);
            for (int k = 0; k < S; k++)
                if (samp(c, n - 2 - k) == m_lvl[c]) flip = 1'b0;
            if (flip) begin
                if (m_lvl[c]) m_rel[c] = 1'b1;
                else begin
                    m_press[c] = 1'b1;
                    press_e[c] = n;
                end
                m_lvl[c]    = ~m_lvl[c];
                last_chg[c] = n;
            end else if (REP_ON && m_lvl[c] && (n - press_e[c] >= D) &&
                         ((n - press_e[c] - D) % T == 0)) begin
                m_rep[c] = 1'b1;
            end
        end
    endtask

    task automatic check_outs();
        chk("level",   32'(btn_level),   32'(m_lvl));
        chk("press",   32'(btn_press),   32'(m_press));
        chk("release", 32'(btn_release), 32'(m_rel));
        chk("repeat",  32'(btn_repeat),  32'(m_rep));
        chk("press_and_release", 32'(btn_press & btn_release), 32'd0);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [CH-1:0] b);
        btn_in = b;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_outs();
        @(negedge clk);
    endtask

    task automatic hold(input logic [CH-1:0] b, input int cycles);
        for (int i = 0; i < cycles; i++) step(b);
    endtask

    task automatic reset_pulse(input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs();
        for (int i = 0; i < cycles; i++) step(btn_in);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [CH-1:0] cur;
        model_reset();
        btn_in = 2'b11;
        @(negedge clk);
        check_outs();
        hold(2'b11, 2);
        rst_n = 1'b1;
        // held buttons through reset: exactly one press each, then steady level
        hold(2'b11, 10);
        chk("held_after_reset", 32'(btn_level), 32'd3);

        hold(2'b00, 10);
        hold(2'b01, 20);
        hold(2'b00, 10);

        for (int r = 0; r < 5; r++) begin
            hold(2'b01, 3);
            hold(2'b00, 1);
        end
        hold(2'b01, 10);
        hold(2'b00, 10);

        hold(2'b01, 4);
        reset_pulse(2);
        hold(2'b01, 10);
        hold(2'b00, 10);

        hold(2'b01, 30);
        hold(2'b00, 15);
        hold(2'b10, 25);
        hold(2'b00, 10);

        cur = '0;
        for (int c = 0; c < CH; c++) left[c] = 0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (left[c] == 0) begin
                    cur[c]  = 1'($urandom_range(0, 1));
                    left[c] = $urandom_range(1, 20);
                end
                left[c]--;
            end
            if (i == 400) reset_pulse(2);
            step(cur);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised N-channel button conditioner for the game's input path, between the board push-buttons and the player/fire control logic. Each channel synchronises its raw input, debounces both press and release against a configurable stability window, and produces a clean level plus single-cycle press and release strobes. An optional auto-repeat strobe supports held buttons such as continuous fire.

## Interface
- CHANNELS, 5: number of independent button channels (≥1).
- STABLE_CYCLES, 16: consecutive stable synchronised samples required to accept a change (≥2).
- REPEAT_DELAY, 12_500_000: cycles from press strobe to first repeat strobe (≥1; used only with repeat enabled).
- REPEAT_PERIOD, 2_500_000: cycles between subsequent repeat strobes (≥1; used only with repeat enabled).
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_in  in  CHANNELS  raw, asynchronous button inputs, active high.
- btn_level  out  CHANNELS  debounced level per channel.
- btn_press  out  CHANNELS  one-cycle strobe on accepted 0→1.
- btn_release  out  CHANNELS  one-cycle strobe on accepted 1→0.
- btn_repeat  out  CHANNELS  one-cycle auto-repeat strobe while held.

## Operation
- Reset (rst_n low, asynchronous): sync flops, counters, btn_level, btn_press, btn_release, btn_repeat all 0. Release of rst_n is synchronous to clk.
- Per channel, fully independent; no cross-channel interaction.
- Synchroniser: two flops; second-stage output is s.
- Stability counter cnt, width $clog2(STABLE_CYCLES): each edge, if s == btn_level then cnt ← 0; else if cnt == STABLE_CYCLES-1 then btn_level ← s, cnt ← 0; else cnt ← cnt+1.
- Any single sample with s == btn_level while counting (glitch) resets cnt to 0; counting restarts from scratch.
- Strobes: btn_press high for exactly the cycle in which btn_level is newly 1; btn_release likewise for newly 0. Never both high in the same cycle on one channel.
- Symmetric: release uses the same STABLE_CYCLES window as press.
- Repeat (when compiled in): repeat counter rcnt cleared on the press acceptance; while btn_level == 1, rcnt increments; btn_repeat pulses when rcnt reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles thereafter. On release acceptance rcnt ← 0 and no further repeat strobes; btn_repeat never coincides with btn_press. rcnt width sized for max(REPEAT_DELAY, REPEAT_PERIOD); it never wraps (reloads on each strobe).

## Timing
- Input change sampled at edge E1 (sync stage 1), s valid after E2; btn_level and strobe update at edge E(2+STABLE_CYCLES), provided btn_in held stable throughout. Latency: STABLE_CYCLES+2 clock edges.
- Strobe width: exactly 1 cycle; cleared on the following edge.
- Input bouncing faster than STABLE_CYCLES never changes btn_level.
- Input pulse shorter than STABLE_CYCLES samples (after synchronisation): no level change, no strobes.
- rst_n asserted mid-count or mid-strobe: all outputs drop to 0 immediately; no strobe emitted on reset release even if btn_in is high — a held button produces btn_press STABLE_CYCLES+2 edges after first sampled post-reset.
- Repeat: first btn_repeat REPEAT_DELAY cycles after btn_press cycle; subsequent strobes spaced exactly REPEAT_PERIOD cycles.

## Configuration
- DEBOUNCE_REPEAT_EN defined: repeat counters and btn_repeat logic built as above.
- DEBOUNCE_REPEAT_EN undefined: no repeat counters synthesised; btn_repeat tied to 0; REPEAT_DELAY/REPEAT_PERIOD ignored. All other behaviour identical.

## Test plan
Bench parameters: CHANNELS=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: rst_n low, btn_in=2'b11 → all outputs 0; after rst_n high, btn_level[1:0]=2'b11 and one btn_press per channel exactly 6 edges after first sampling edge.
- Clean press/release ch0: btn_in[0] 0→1 held 20 cycles then 0 → btn_press[0] 1 cycle at edge 6, btn_release[0] 1 cycle 6 edges after the falling sample; ch1 outputs stay 0.
- Bounce: btn_in[0] toggles high 3 cycles/low 1 cycle ×5 → btn_level[0] stays 0, no strobes; then held high → press 6 edges after final rise.
- Reset mid-operation: rst_n low 2 cycles while ch0 counter at 2 → all outputs 0 at once; press observed 6 edges after reset release with btn_in held.
- Repeat (macro defined): hold btn_in[0] 30 cycles → btn_press at cycle P, btn_repeat at P+10, P+13, P+16, …; stops after release acceptance.
- Repeat (macro undefined): same stimulus → btn_repeat constantly 0, press/release timing unchanged.
